// File: rtl/lii_req_arbiter.sv
// ---------------------------------------------------------------------------
// lii_req_arbiter
//
// Merges N_REQ requester flit streams onto one LII request stream. Packets
// are arbitrated round-robin and are never interleaved. A packet owns the
// output from its first flit until its tlast flit has been accepted into the
// output register.
//
// State table
//   state | meaning
//   ARB   | no owner; grant=0, all s_tready=0; pick a winner among valid reqs
//   OWN   | one requester owns the stream until its tlast beat is accepted
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   s_tdata/tkeep/tstrb/tlast/src/dst/tvalid
//                      per-requester flit inputs, requester i in slice i
//   s_tready           per-requester ready; only the owner can be ready
//   m_tdata/tkeep/tstrb/tlast/src/dst/tvalid
//                      merged output stream, fully registered
//   m_tready           downstream ready
//   grant              one-hot current owner, zero when unowned
//   pkt_cnt            packets accepted downstream (tlast beats), wraps
// ---------------------------------------------------------------------------
module lii_req_arbiter #(
  parameter int N_REQ  = 4,
  parameter int LII_DW = 256
) (
  input  logic                      clk,
  input  logic                      rstn,

  input  logic [N_REQ*LII_DW-1:0]   s_tdata,
  input  logic [N_REQ*LII_DW/8-1:0] s_tkeep,
  input  logic [N_REQ*LII_DW/8-1:0] s_tstrb,
  input  logic [N_REQ-1:0]          s_tlast,
  input  logic [N_REQ*8-1:0]        s_src,
  input  logic [N_REQ*8-1:0]        s_dst,
  input  logic [N_REQ-1:0]          s_tvalid,
  output logic [N_REQ-1:0]          s_tready,

  output logic [LII_DW-1:0]         m_tdata,
  output logic [LII_DW/8-1:0]       m_tkeep,
  output logic [LII_DW/8-1:0]       m_tstrb,
  output logic                      m_tlast,
  output logic [7:0]                m_src,
  output logic [7:0]                m_dst,
  output logic                      m_tvalid,
  input  logic                      m_tready,

  output logic [N_REQ-1:0]          grant,
  output logic [15:0]               pkt_cnt
);

  localparam int KW = LII_DW / 8;
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] GRANT_LSB = N_REQ'(1);

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_ptr;

  logic          out_free;
  logic          src_xfer;

  logic [LII_DW-1:0] sel_data;
  logic [KW-1:0]     sel_keep;
  logic [KW-1:0]     sel_strb;
  logic              sel_last;
  logic [7:0]        sel_src;
  logic [7:0]        sel_dst;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   cand;

  // The output register can take a new beat when it is empty or being
  // drained this cycle.
  assign out_free = !m_tvalid || m_tready;

  always_comb begin
    s_tready = '0;
    if (state == OWN) begin
      s_tready = grant & {N_REQ{out_free}};
    end
  end

  // s_tready is only ever set for the owner, so any handshake is the owner's.
  assign src_xfer = |(s_tvalid & s_tready);

  assign sel_data = s_tdata[owner*LII_DW +: LII_DW];
  assign sel_keep = s_tkeep[owner*KW +: KW];
  assign sel_strb = s_tstrb[owner*KW +: KW];
  assign sel_last = s_tlast[owner];
  assign sel_src  = s_src[owner*8 +: 8];
  assign sel_dst  = s_dst[owner*8 +: 8];

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  // cand is one bit wider than an index so rr_ptr + k never overflows
  // before the wrap correction.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!win_found && s_tvalid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    if (owner == IW'(N_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = owner + IW'(1);
    end
  end

  // Arbitration / ownership FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ARB;
      owner  <= '0;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      case (state)
        ARB: begin
          if (win_found) begin
            grant <= GRANT_LSB << win_idx;
            owner <= win_idx;
            state <= OWN;
          end
        end
        OWN: begin
          // Release on the edge the tlast beat enters the output register;
          // the next owner search starts just above the finished owner.
          if (src_xfer && sel_last) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
            state  <= ARB;
          end
        end
        default: begin
          grant <= '0;
          state <= ARB;
        end
      endcase
    end
  end

  // Output register: loads on a source handshake, otherwise holds its
  // fields and only drops valid once the downstream has taken the beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tstrb  <= '0;
      m_tlast  <= 1'b0;
      m_src    <= '0;
      m_dst    <= '0;
      m_tvalid <= 1'b0;
    end else begin
      if (src_xfer) begin
        m_tdata  <= sel_data;
        m_tkeep  <= sel_keep;
        m_tstrb  <= sel_strb;
        m_tlast  <= sel_last;
        m_src    <= sel_src;
        m_dst    <= sel_dst;
        m_tvalid <= 1'b1;
      end else if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt <= '0;
    end else if (m_tvalid && m_tready && m_tlast) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_lii_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lii_req_arbiter
//
// Per-requester source queues drive the DUT; every flit a test expects on the
// merged output is pushed, in the order the test expects it, onto exp_q when
// the stimulus is queued. The monitor in tick() pops and compares one entry
// per accepted output beat. Grant transitions are logged for order checks.
// ---------------------------------------------------------------------------
module tb_lii_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int KW = DW / 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [N*DW-1:0]   s_tdata = '0;
  logic [N*KW-1:0]   s_tkeep = '0;
  logic [N*KW-1:0]   s_tstrb = '0;
  logic [N-1:0]      s_tlast = '0;
  logic [N*8-1:0]    s_src = '0;
  logic [N*8-1:0]    s_dst = '0;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [KW-1:0]     m_tstrb;
  logic              m_tlast;
  logic [7:0]        m_src;
  logic [7:0]        m_dst;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [N-1:0]      grant;
  logic [15:0]       pkt_cnt;

  always #5 clk = ~clk;

  lii_req_arbiter #(.N_REQ(N), .LII_DW(DW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tstrb  (s_tstrb),
    .s_tlast  (s_tlast),
    .s_src    (s_src),
    .s_dst    (s_dst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tstrb  (m_tstrb),
    .m_tlast  (m_tlast),
    .m_src    (m_src),
    .m_dst    (m_dst),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .grant    (grant),
    .pkt_cnt  (pkt_cnt)
  );

  typedef struct packed {
    logic          bubble;
    logic          last;
    logic [7:0]    src;
    logic [7:0]    dst;
    logic [KW-1:0] keep;
    logic [KW-1:0] strb;
    logic [DW-1:0] data;
  } flit_t;

  flit_t        src_q[N][$];
  flit_t        exp_q[$];
  logic [N-1:0] grant_log[$];
  logic [N-1:0] prev_grant = '0;
  int           out_cyc[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;

  function automatic flit_t mk_flit(input int req, input int pkt, input int beat, input bit last);
    flit_t f;
    logic [31:0] w;
    w      = {8'(req), 8'(pkt), 16'(beat)};
    f      = '0;
    f.data = {(DW/32){w}};
    f.keep = last ? (32'hFFFF_FFFF >> (beat + 1)) : 32'hFFFF_FFFF;
    f.strb = f.keep ^ 32'(pkt * 7);
    f.last = last;
    f.src  = 8'(req);
    f.dst  = 8'(8'h40 + pkt);
    return f;
  endfunction

  // Queue a packet on requester req, with gap_len idle cycles inserted
  // before beat gap_at (gap_at < 0 for none); also expect it downstream.
  task automatic push_pkt(input int req, input int pkt, input int nbeats,
                          input int gap_at, input int gap_len);
    flit_t f;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          f = '0;
          f.bubble = 1'b1;
          src_q[req].push_back(f);
        end
      end
      f = mk_flit(req, pkt, b, b == nbeats - 1);
      src_q[req].push_back(f);
      exp_q.push_back(f);
    end
  endtask

  task automatic push_idle(input int req, input int n);
    flit_t f;
    f = '0;
    f.bubble = 1'b1;
    for (int g = 0; g < n; g++) src_q[req].push_back(f);
  endtask

  function automatic bit src_busy();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive sources, sample handshakes at the falling edge,
  // consume/score at the rising edge, then settle 1ns for test checks.
  task automatic tick();
    logic [N-1:0] xfer;
    logic         mon;
    flit_t        got;
    flit_t        e;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !src_q[i][0].bubble) begin
        s_tvalid[i]             = 1'b1;
        s_tdata[i*DW +: DW]     = src_q[i][0].data;
        s_tkeep[i*KW +: KW]     = src_q[i][0].keep;
        s_tstrb[i*KW +: KW]     = src_q[i][0].strb;
        s_tlast[i]              = src_q[i][0].last;
        s_src[i*8 +: 8]         = src_q[i][0].src;
        s_dst[i*8 +: 8]         = src_q[i][0].dst;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
    @(negedge clk);
    xfer     = s_tvalid & s_tready;
    mon      = m_tvalid & m_tready;
    got      = '0;
    got.last = m_tlast;
    got.src  = m_src;
    got.dst  = m_dst;
    got.keep = m_tkeep;
    got.strb = m_tstrb;
    got.data = m_tdata;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        if (src_q[i][0].bubble || xfer[i]) void'(src_q[i].pop_front());
      end
    end
    if (mon) begin
      out_cyc.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL flit_unexpected: got src=%0d word=%h, required no flit",
                 got.src, got.data[31:0]);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL flit_check: got src=%0d dst=%h last=%0b keep=%h strb=%h word=%h, required src=%0d dst=%h last=%0b keep=%h strb=%h word=%h",
                   got.src, got.dst, got.last, got.keep, got.strb, got.data[31:0],
                   e.src, e.dst, e.last, e.keep, e.strb, e.data[31:0]);
        end
      end
    end
    #1;
    cyc++;
    if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
    prev_grant = grant;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || src_busy()) && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d flits still outstanding after %0d cycles, required 0",
               name, exp_q.size(), n);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    repeat (2) tick();
    rstn = 1'b1;
    grant_log.delete();
    out_cyc.delete();
    prev_grant = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_tvalid = 4'b1111;
    #3;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_m_tvalid: got %b, required 0", m_tvalid); end
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b, required 0000", grant); end
    n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL reset_s_tready: got %b, required 0000", s_tready); end
    n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_pkt_cnt: got %0d, required 0", pkt_cnt); end
    n_cmp++; if ({m_tdata, m_tkeep, m_tstrb, m_tlast, m_src, m_dst} !== '0) begin
      n_bad++; $display("FAIL reset_m_fields: got word=%h src=%h last=%b, required all zero", m_tdata[31:0], m_src, m_tlast);
    end
    s_tvalid = '0;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    push_pkt(2, 1, 3, -1, 0);
    tick();
    n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b, required 0100", grant); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b, required 0", m_tvalid); end
    tick();
    n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b, required 1", m_tvalid); end
    tick();
    tick();
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL single_release: got %b, required 0000", grant); end
    tick();
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL single_pkt_cnt: got %0d, required 1", pkt_cnt); end
    n_cmp++;
    if (out_cyc.size() != 3 || (out_cyc[2] - out_cyc[0]) != 2) begin
      n_bad++; $display("FAIL single_contiguous: got %0d beats spanning %0d cycles, required 3 beats spanning 2",
                        out_cyc.size(), out_cyc.size() == 3 ? out_cyc[2] - out_cyc[0] : -1);
    end
    drain("single");
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g[5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    push_pkt(0, 1, 1, -1, 0);
    push_pkt(1, 2, 1, -1, 0);
    push_pkt(2, 3, 1, -1, 0);
    push_pkt(3, 4, 1, -1, 0);
    push_pkt(0, 5, 1, -1, 0);
    drain("rr");
    n_cmp++; if (grant_log.size() != 5) begin n_bad++; $display("FAIL rr_grant_count: got %0d, required 5", grant_log.size()); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (k >= grant_log.size() || grant_log[k] !== exp_g[k]) begin
        n_bad++; $display("FAIL rr_grant_order[%0d]: got %b, required %b", k,
                          k < grant_log.size() ? grant_log[k] : 4'bxxxx, exp_g[k]);
      end
    end
    n_cmp++; if (pkt_cnt !== 16'd5) begin n_bad++; $display("FAIL rr_pkt_cnt: got %0d, required 5", pkt_cnt); end
  endtask

  task automatic test_no_interleave();
    do_reset();
    push_pkt(0, 6, 4, -1, 0);
    push_pkt(1, 7, 1, -1, 0);
    drain("no_interleave");
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] !== 4'b0001 || grant_log[1] !== 4'b0010) begin
      n_bad++; $display("FAIL no_interleave_grants: got %0d grants first=%b, required 0001 then 0010",
                        grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 4'bxxxx);
    end
    n_cmp++; if (pkt_cnt !== 16'd2) begin n_bad++; $display("FAIL no_interleave_pkt_cnt: got %0d, required 2", pkt_cnt); end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    push_pkt(0, 8, 6, -1, 0);
    n = 0;
    while (exp_q.size() > 4 && n < 50) begin tick(); n++; end
    n_cmp++;
    if (exp_q.size() != 4) begin
      n_bad++; $display("FAIL bp_start_timeout: got %0d outstanding, required 4", exp_q.size());
    end else begin
      m_tready = 1'b0;
      for (int t = 0; t < 5; t++) begin
        tick();
        n_cmp++; if (m_tvalid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b, required 1", t, m_tvalid); end
        n_cmp++; if (m_tdata !== exp_q[0].data || m_src !== exp_q[0].src || m_tlast !== exp_q[0].last) begin
          n_bad++; $display("FAIL bp_frozen[%0d]: got word=%h src=%0d, required word=%h src=%0d",
                            t, m_tdata[31:0], m_src, exp_q[0].data[31:0], exp_q[0].src);
        end
        n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL bp_s_tready[%0d]: got %b, required 0000", t, s_tready); end
      end
      m_tready = 1'b1;
    end
    drain("bp");
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL bp_pkt_cnt: got %0d, required 1", pkt_cnt); end
  endtask

  task automatic test_owner_gap();
    do_reset();
    push_pkt(3, 9, 5, 2, 3);
    push_idle(1, 2);
    push_pkt(1, 10, 2, -1, 0);
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t <= 8) begin
        n_cmp++; if (grant !== 4'b1000) begin n_bad++; $display("FAIL gap_grant_held[%0d]: got %b, required 1000", t, grant); end
      end else if (t == 9) begin
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL gap_release: got %b, required 0000", grant); end
      end else begin
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL gap_next_owner: got %b, required 0010", grant); end
      end
      if (t == 5) begin
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL gap_m_tvalid: got %b, required 0", m_tvalid); end
      end
    end
    drain("gap");
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    push_pkt(1, 11, 1, -1, 0);
    drain("mid_pre");
    n_cmp++; if (pkt_cnt !== 16'd1) begin n_bad++; $display("FAIL mid_pre_pkt_cnt: got %0d, required 1", pkt_cnt); end
    push_pkt(2, 12, 4, -1, 0);
    n = 0;
    while (exp_q.size() > 2 && n < 50) begin tick(); n++; end
    n_cmp++; if (exp_q.size() != 2) begin n_bad++; $display("FAIL mid_start_timeout: got %0d outstanding, required 2", exp_q.size()); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_m_tvalid: got %b, required 0", m_tvalid); end
    n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL mid_grant: got %b, required 0000", grant); end
    n_cmp++; if (pkt_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_pkt_cnt: got %0d, required 0", pkt_cnt); end
    n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL mid_s_tready: got %b, required 0000", s_tready); end
    do_reset();
    push_pkt(0, 13, 1, -1, 0);
    push_pkt(3, 14, 2, -1, 0);
    drain("mid_post");
    n_cmp++;
    if (grant_log.size() != 2 || grant_log[0] !== 4'b0001 || grant_log[1] !== 4'b1000) begin
      n_bad++; $display("FAIL mid_restart_order: got %0d grants first=%b, required 0001 then 1000",
                        grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 4'bxxxx);
    end
    n_cmp++; if (pkt_cnt !== 16'd2) begin n_bad++; $display("FAIL mid_post_pkt_cnt: got %0d, required 2", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_interleave();
    test_backpressure();
    test_owner_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
